// File: rtl/qracc_sram_ctrl.sv
// qracc_sram_ctrl: sequences precharge/wordline/sense phases of the QrAcc SRAM array for single read/write requests
module qracc_sram_ctrl #(
    parameter int numRows = 128,
    parameter int numCols = 32,
    parameter int T_PCH   = 2,
    parameter int T_WL    = 2,
    parameter int T_SA    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lock_i,
    input  logic                       rq_wr_i,
    input  logic                       rq_valid_i,
    output logic                       rq_ready_o,
    input  logic [$clog2(numRows)-1:0] addr_i,
    input  logic [numCols-1:0]         wr_data_i,
    output logic                       rd_valid_o,
    output logic [numCols-1:0]         rd_data_o,
    output logic [numRows-1:0]         WL,
    output logic                       PCH,
    output logic [numCols-1:0]         WR_DATA,
    output logic                       WRITE,
    output logic [numCols-1:0]         CSEL,
    output logic                       SAEN,
    input  logic [numCols-1:0]         SA_OUT
);
    localparam int AW   = $clog2(numRows);
    localparam int TMAX = (T_PCH > T_WL) ? ((T_PCH > T_SA) ? T_PCH : T_SA) : ((T_WL > T_SA) ? T_WL : T_SA);
    localparam int CW   = $clog2(TMAX + 1);
    typedef enum logic [1:0] {IDLE, PRECHARGE, ACCESS, SENSE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] addr_q;
    logic wr_q;
    logic [numCols-1:0] data_q;
    logic [numRows-1:0] wl_dec;
    logic accept, sense_done, row_on;
    assign rq_ready_o = (state == IDLE) && !lock_i;
    assign accept     = rq_valid_i && rq_ready_o;
    assign sense_done = (state == SENSE) && (cnt == '0);
    assign row_on     = (state_n == ACCESS) || (state_n == SENSE);
    // Out-of-range addresses match no row, leaving WL all zero
    always_comb begin
        for (int i = 0; i < numRows; i++) wl_dec[i] = (addr_q == AW'(i));
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt - CW'(1);
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (accept) begin
                    state_n = PRECHARGE;
                    cnt_n   = CW'(T_PCH - 1);
                end
            end
            PRECHARGE: if (cnt == '0) begin
                state_n = ACCESS;
                cnt_n   = CW'(T_WL - 1);
            end
            ACCESS: if (cnt == '0) begin
                state_n = wr_q ? IDLE : SENSE;
                cnt_n   = CW'(T_SA - 1);
            end
            SENSE: if (cnt == '0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // Analog controls are decoded from the next state and registered so they never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            data_q     <= '0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            WL         <= '0;
            PCH        <= 1'b0;
            WR_DATA    <= '0;
            WRITE      <= 1'b0;
            CSEL       <= '0;
            SAEN       <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                addr_q <= addr_i;
                wr_q   <= rq_wr_i;
                data_q <= wr_data_i;
            end
            PCH        <= state_n == PRECHARGE;
            WL         <= row_on ? wl_dec : '0;
            CSEL       <= row_on ? '1 : '0;
            WRITE      <= (state_n == ACCESS) && wr_q;
            WR_DATA    <= ((state_n == ACCESS) && wr_q) ? data_q : '0;
            SAEN       <= state_n == SENSE;
            rd_valid_o <= sense_done;
            if (sense_done) rd_data_o <= (|WL) ? SA_OUT : '0;
        end
    end
endmodule
